// File: rtl/column_run_counter.sv
`default_nettype none
// =============================================================================
// column_run_counter : run-length encodes a column-index stream into an output FIFO
// Revision 1.0
// =============================================================================
module column_run_counter #(
  parameter int IDX_W      = 32,
  parameter int CNT_W      = 5,
  parameter int TIMEOUT    = 63,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_col_index,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_col_index,
  output logic [CNT_W-1:0] out_count,
  output logic             idle
);

  localparam int c_addr_w = $clog2(FIFO_DEPTH);
  localparam int c_ent_w  = IDX_W + CNT_W;

  localparam logic [CNT_W-1:0]  c_cmax       = '1;
  localparam logic [CNT_W-1:0]  c_cnt_one    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]       c_timeout    = 16'(TIMEOUT);
  localparam logic [15:0]       c_timeout_m1 = 16'(TIMEOUT - 1);
  localparam logic [15:0]       c_timer_one  = 16'd1;
  localparam logic [c_addr_w:0] c_ptr_one    = {{c_addr_w{1'b0}}, 1'b1};

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_open = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [IDX_W-1:0] r_cur_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [CNT_W-1:0] r_cur_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [15:0]      r_timer;
  logic [15:0]      w_timer_nxt;

  logic             w_emit;
  logic [IDX_W-1:0] w_emit_idx;
  logic [CNT_W-1:0] w_emit_cnt;

  logic [c_ent_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_addr_w:0]  r_wr_ptr;
  logic [c_addr_w:0]  r_rd_ptr;
  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic               w_pop;

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                    (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
  assign w_accept = in_valid && !w_full;
  assign w_pop    = !w_empty && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_cur_idx;
    w_cnt_nxt   = r_cur_cnt;
    w_timer_nxt = r_timer;
    w_emit      = 1'b0;
    w_emit_idx  = r_cur_idx;
    w_emit_cnt  = r_cur_cnt;
    case (r_state)
      c_st_idle: begin
        if (w_accept) begin
          w_state_nxt = c_st_open;
          w_idx_nxt   = in_col_index;
          w_cnt_nxt   = c_cnt_one;
          w_timer_nxt = '0;
        end
      end
      c_st_open: begin
        if (w_accept) begin
          w_timer_nxt = '0;
          if ((in_col_index == r_cur_idx) && (r_cur_cnt != c_cmax)) begin
            w_cnt_nxt = r_cur_cnt + c_cnt_one;
            if (flush) begin
              w_emit      = 1'b1;
              w_emit_cnt  = r_cur_cnt + c_cnt_one;
              w_state_nxt = c_st_idle;
              w_cnt_nxt   = '0;
            end
          end else begin
            // Index change or saturated count closes the run; flush cannot close the new one.
            w_emit    = 1'b1;
            w_idx_nxt = in_col_index;
            w_cnt_nxt = c_cnt_one;
          end
        end else if ((flush || (r_timer >= c_timeout_m1)) && !w_full) begin
          w_emit      = 1'b1;
          w_state_nxt = c_st_idle;
          w_cnt_nxt   = '0;
          w_timer_nxt = '0;
        end else if (r_timer != c_timeout) begin
          w_timer_nxt = r_timer + c_timer_one;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    in_ready      = !w_full;
    out_valid     = !w_empty;
    idle          = (r_state == c_st_idle) && w_empty;
    out_col_index = '0;
    out_count     = '0;
    if (!w_empty) begin
      {out_col_index, out_count} = r_mem[r_rd_ptr[c_addr_w-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_idx <= '0;
      r_cur_cnt <= '0;
      r_timer   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
    end else begin
      r_cur_idx <= w_idx_nxt;
      r_cur_cnt <= w_cnt_nxt;
      r_timer   <= w_timer_nxt;
      if (w_emit) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
    end
  end

  // Storage needs no reset: the read mux hides stale entries while empty.
  always_ff @(posedge clk) begin
    if (w_emit) begin
      r_mem[r_wr_ptr[c_addr_w-1:0]] <= {w_emit_idx, w_emit_cnt};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_column_run_counter.sv
`default_nettype none
// =============================================================================
// tb_column_run_counter : directed scenarios plus randomized run against a queue model
// Revision 1.0
// =============================================================================
module tb_column_run_counter;

  localparam int c_depth   = 4;
  localparam int c_timeout = 63;
  localparam int c_cmax    = 31;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_col_index = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_col_index;
  logic [4:0]  out_count;
  logic        idle;

  int checks   = 0;
  int failures = 0;

  column_run_counter #(
    .IDX_W(32), .CNT_W(5), .TIMEOUT(c_timeout), .FIFO_DEPTH(c_depth)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_col_index(in_col_index), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_col_index(out_col_index), .out_count(out_count),
    .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic cycle(input logic v, input logic [31:0] d, input logic fl, input logic ordy);
    in_valid = v; in_col_index = d; flush = fl; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%0b exp=1", idle); end
    checks++; if (out_count !== 5'd0) begin failures++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
    checks++; if (out_col_index !== 32'd0) begin failures++; $display("FAIL reset_out_idx got=%0d exp=0", out_col_index); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle(1'b1, 32'd5, 1'b0, 1'b1);
    cycle(1'b1, 32'd5, 1'b0, 1'b1);
    cycle(1'b1, 32'd5, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_early_valid got=%0b exp=0", out_valid); end
    cycle(1'b1, 32'd9, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_col_index !== 32'd5 || out_count !== 5'd3) begin
      failures++; $display("FAIL b2b_run got=(%0b,%0d,%0d) exp=(1,5,3)", out_valid, out_col_index, out_count);
    end
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0 || idle !== 1'b0) begin
      failures++; $display("FAIL b2b_after_pop got=(valid %0b idle %0b) exp=(0,0)", out_valid, idle);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    cycle(1'b1, 32'd7, 1'b0, 1'b0);
    for (int i = 0; i < c_timeout - 1; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0 || idle !== 1'b0) begin
      failures++; $display("FAIL timeout_early got=(valid %0b idle %0b) exp=(0,0)", out_valid, idle);
    end
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_col_index !== 32'd7 || out_count !== 5'd1) begin
      failures++; $display("FAIL timeout_emit got=(%0b,%0d,%0d) exp=(1,7,1)", out_valid, out_col_index, out_count);
    end
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    checks++; if (idle !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL timeout_idle got=(idle %0b valid %0b) exp=(1,0)", idle, out_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 33; i++) cycle(1'b1, 32'd4, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_col_index !== 32'd4 || out_count !== 5'd31) begin
      failures++; $display("FAIL sat_emit got=(%0b,%0d,%0d) exp=(1,4,31)", out_valid, out_col_index, out_count);
    end
    cycle(1'b0, 32'd0, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_col_index !== 32'd4 || out_count !== 5'd2) begin
      failures++; $display("FAIL sat_flush got=(%0b,%0d,%0d) exp=(1,4,2)", out_valid, out_col_index, out_count);
    end
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL sat_idle got=%0b exp=1", idle); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] exp_idx [4];
    exp_idx = '{32'd1, 32'd2, 32'd1, 32'd2};
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, (i % 2 == 0) ? 32'd1 : 32'd2, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
    cycle(1'b1, 32'd2, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_hold got=%0b exp=0", in_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_col_index !== exp_idx[i] || out_count !== 5'd1) begin
        failures++; $display("FAIL full_drain%0d got=(%0b,%0d,%0d) exp=(1,%0d,1)", i, out_valid, out_col_index, out_count, exp_idx[i]);
      end
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
    end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL full_empty got=(valid %0b ready %0b) exp=(0,1)", out_valid, in_ready);
    end
  endtask

  task automatic test_flush_input();
    do_reset();
    cycle(1'b1, 32'd3, 1'b0, 1'b0);
    cycle(1'b1, 32'd3, 1'b0, 1'b0);
    cycle(1'b1, 32'd3, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_col_index !== 32'd3 || out_count !== 5'd3) begin
      failures++; $display("FAIL flush_eq got=(%0b,%0d,%0d) exp=(1,3,3)", out_valid, out_col_index, out_count);
    end
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL flush_eq_idle got=%0b exp=1", idle); end
    cycle(1'b1, 32'd3, 1'b0, 1'b0);
    cycle(1'b1, 32'd3, 1'b0, 1'b0);
    cycle(1'b1, 32'd8, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_col_index !== 32'd3 || out_count !== 5'd2) begin
      failures++; $display("FAIL flush_ne got=(%0b,%0d,%0d) exp=(1,3,2)", out_valid, out_col_index, out_count);
    end
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    checks++; if (idle !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_ne_open got=(idle %0b valid %0b) exp=(0,0)", idle, out_valid);
    end
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_col_index !== 32'd8 || out_count !== 5'd1) begin
      failures++; $display("FAIL flush_new_run got=(%0b,%0d,%0d) exp=(1,8,1)", out_valid, out_col_index, out_count);
    end
  endtask

  task automatic test_reset_mid_run();
    logic saw_valid;
    do_reset();
    cycle(1'b1, 32'd1, 1'b0, 1'b0);
    cycle(1'b1, 32'd2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'd6, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0b exp=1", out_valid); end
    reset = 1'b1;
    cycle(1'b1, 32'd6, 1'b1, 1'b1);
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || idle !== 1'b1 || in_ready !== 1'b1) begin
      failures++; $display("FAIL mid_reset got=(valid %0b idle %0b ready %0b) exp=(0,1,1)", out_valid, idle, in_ready);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 2 * c_timeout; i++) begin
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
      saw_valid |= out_valid;
    end
    checks++; if (saw_valid !== 1'b0 || idle !== 1'b1) begin
      failures++; $display("FAIL mid_ghost got=(seen %0b idle %0b) exp=(0,1)", saw_valid, idle);
    end
  endtask

  task automatic test_random();
    logic [31:0] q_idx [$];
    logic [4:0]  q_cnt [$];
    bit          m_open;
    logic [31:0] m_idx;
    int          m_cnt, m_idle;
    bit          v, fl, ordy, acc, full, pop, emit;
    logic [31:0] d, e_idx;
    int          e_cnt;
    do_reset();
    m_open = 0; m_idx = '0; m_cnt = 0; m_idle = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      checks++;
      if (out_valid !== (q_idx.size() > 0) || in_ready !== (q_idx.size() < c_depth) ||
          idle !== (!m_open && q_idx.size() == 0)) begin
        failures++;
        $display("FAIL rnd_status cyc=%0d got=(v%0b r%0b i%0b) exp=(v%0b r%0b i%0b)", cyc,
                 out_valid, in_ready, idle, q_idx.size() > 0, q_idx.size() < c_depth,
                 !m_open && q_idx.size() == 0);
      end
      if (q_idx.size() > 0) begin
        checks++;
        if (out_col_index !== q_idx[0] || out_count !== q_cnt[0]) begin
          failures++;
          $display("FAIL rnd_head cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)", cyc, out_col_index, out_count, q_idx[0], q_cnt[0]);
        end
      end
      // Alternate busy and sparse phases so timeouts and back-pressure both occur.
      if ((cyc / 300) % 2 == 0) v = ($urandom_range(0, 99) < 70);
      else                      v = ($urandom_range(0, 99) < 2);
      d    = 32'($urandom_range(0, 2));
      fl   = ($urandom_range(0, 99) < 4);
      ordy = ((cyc / 150) % 2 == 0) ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 15);

      full = (q_idx.size() == c_depth);
      acc  = v && !full;
      pop  = (q_idx.size() > 0) && ordy;
      emit = 0; e_idx = m_idx; e_cnt = m_cnt;
      if (!m_open) begin
        if (acc) begin m_open = 1; m_idx = d; m_cnt = 1; m_idle = 0; end
      end else if (acc) begin
        m_idle = 0;
        if (d == m_idx && m_cnt < c_cmax) begin
          m_cnt++;
          if (fl) begin emit = 1; e_cnt = m_cnt; m_open = 0; end
        end else begin
          emit = 1; m_idx = d; m_cnt = 1;
        end
      end else begin
        m_idle++;
        if ((fl || m_idle >= c_timeout) && !full) begin emit = 1; m_open = 0; end
      end
      if (pop) begin void'(q_idx.pop_front()); void'(q_cnt.pop_front()); end
      if (emit) begin q_idx.push_back(e_idx); q_cnt.push_back(5'(e_cnt)); end
      cycle(v, d, fl, ordy);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_timeout();
    test_saturation();
    test_fifo_full();
    test_flush_input();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
